// File: rtl/alu_pkg.sv
// Shared encodings for the iterative execute-stage ALU: opcodes, FSM states,
// the illegal-op default result and the mul/div decode helpers.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_LUI    = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [63:0] DEF_RES_DFLT = 64'hDEAD_BEEF;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} alu_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Issue/result handshake bundle between the ID/EX stage, the ALU and EX/MEM.
interface alu_iter_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [OP_W-1:0] op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            illegal_o;

  modport master (
    output flush_i, valid_i, op_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o, illegal_o
  );

  modport slave (
    input  flush_i, valid_i, op_i, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o, illegal_o
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiplier / restoring divider sharing one 2*XLEN shift register
// and one XLEN+1-bit adder. Divider path present only with ALU_ITER_DIV_EN.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] p_q, p_d, full;
  logic [XLEN-1:0]   m_q, m_d, ma, mb;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic              busy_q, busy_d, neg_q, neg_d, sa, sb;
  logic [XLEN:0]     add_a, add_b;
  logic              add_ci;
  logic [XLEN+1:0]   sum;
  logic              unused_sum;

  assign sa = a_i[XLEN-1] & ((op_i == OP_MUL) | (op_i == OP_MULH) | (op_i == OP_MULHSU) |
                             (op_i == OP_DIV) | (op_i == OP_REM));
  assign sb = b_i[XLEN-1] & ((op_i == OP_MUL) | (op_i == OP_MULH) |
                             (op_i == OP_DIV) | (op_i == OP_REM));
  assign ma = sa ? -a_i : a_i;
  assign mb = sb ? -b_i : b_i;

  // Divide uses the adder as a subtractor; carry out means "no borrow".
  always_comb begin
    add_a  = {1'b0, p_q[2*XLEN-1:XLEN]};
    add_b  = {1'b0, m_q};
    add_ci = 1'b0;
`ifdef ALU_ITER_DIV_EN
    if (is_div(op_q)) begin
      add_a  = p_q[2*XLEN-1:XLEN-1];
      add_b  = ~{1'b0, m_q};
      add_ci = 1'b1;
    end
`endif
    sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_ci};
  end
  assign unused_sum = sum[XLEN+1];

  assign done_o = busy_q & (cnt_q == CW'(XLEN-1));
  assign busy_o = busy_q;

  always_comb begin
    p_d = p_q; m_d = m_q; cnt_d = cnt_q; busy_d = busy_q; neg_d = neg_q; op_d = op_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op_i;
      neg_d  = (op_i == OP_REM) ? sa : (sa ^ sb);
      p_d    = {{XLEN{1'b0}}, mb};
      m_d    = ma;
`ifdef ALU_ITER_DIV_EN
      if (is_div(op_i)) begin
        p_d = {{XLEN{1'b0}}, ma};
        m_d = mb;
      end
`endif
    end else if (busy_q) begin
      cnt_d  = cnt_q + CW'(1);
      busy_d = ~done_o;
      p_d    = p_q[0] ? {sum[XLEN:0], p_q[XLEN-1:1]} : {1'b0, p_q[2*XLEN-1:1]};
`ifdef ALU_ITER_DIV_EN
      if (is_div(op_q))
        p_d = sum[XLEN+1] ? {sum[XLEN-1:0], p_q[XLEN-2:0], 1'b1} : {p_q[2*XLEN-2:0], 1'b0};
`endif
    end
    if (abort_i) busy_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0; m_q <= '0; cnt_q <= '0; busy_q <= 1'b0; neg_q <= 1'b0; op_q <= OP_MUL;
    end else begin
      p_q <= p_d; m_q <= m_d; cnt_q <= cnt_d; busy_q <= busy_d; neg_q <= neg_d; op_q <= op_d;
    end
  end

  always_comb begin
    full     = neg_q ? -p_q : p_q;
    result_o = (op_q == OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
`ifdef ALU_ITER_DIV_EN
    if (is_div(op_q)) begin
      if ((op_q == OP_REM) || (op_q == OP_REMU))
        result_o = neg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
      else
        result_o = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    end
`endif
  end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle base ops, iterative MUL*, and DIV*/REM*
// when ALU_ITER_DIV_EN is defined (otherwise those opcodes report illegal).
module alu_iter import alu_pkg::*; #(
  parameter int          XLEN    = 32,
  parameter int          OP_W    = 5,
  parameter logic [63:0] DEF_RES = DEF_RES_DFLT
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  alu_iter_if.slave alu_if
);
  localparam int SHW = $clog2(XLEN);
`ifdef ALU_ITER_DIV_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] res_q, res_d, base_res, md_res, a, b;
  logic            ill_q, ill_d, sel_q, sel_d;
  logic [4:0]      op;
  logic [SHW-1:0]  sh;
  logic            op_rng, accept, md_start, md_busy, md_done;

  assign a      = alu_if.a_i;
  assign b      = alu_if.b_i;
  assign op     = 5'(alu_if.op_i);
  assign op_rng = ((alu_if.op_i >> 5) == '0);
  assign sh     = b[SHW-1:0];

  assign alu_if.ready_o = rst_ni & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & alu_if.ready_i));
  assign accept         = alu_if.ready_o & alu_if.valid_i & ~alu_if.flush_i;

  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_SLL:  base_res = a << sh;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  base_res = a ^ b;
      OP_SRL:  base_res = a >> sh;
      OP_SRA:  base_res = $signed(a) >>> sh;
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      OP_LUI:  base_res = b;
      default: base_res = '0;
    endcase
  end

  // Accept in DONE overrides the return to IDLE; flush overrides everything.
  always_comb begin
    state_d = state_q; res_d = res_q; ill_d = ill_q; sel_d = sel_q; md_start = 1'b0;
    case (state_q)
      ST_MUL, ST_DIV: if (md_done) state_d = ST_DONE;
      ST_DONE:        if (alu_if.ready_i) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = ST_DONE; sel_d = 1'b0; ill_d = 1'b0; res_d = base_res;
      if (!op_rng || (op > OP_REMU)) begin
        ill_d = 1'b1; res_d = XLEN'(DEF_RES);
      end else if (is_muldiv(op) && !is_div(op)) begin
        state_d = ST_MUL; sel_d = 1'b1; md_start = 1'b1;
      end else if (is_div(op)) begin
`ifdef ALU_ITER_DIV_EN
        if (b == '0)
          res_d = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
        else if (((op == OP_DIV) || (op == OP_REM)) && (a == SMIN) && (b == '1))
          res_d = (op == OP_DIV) ? a : '0;
        else begin
          state_d = ST_DIV; sel_d = 1'b1; md_start = 1'b1;
        end
`else
        ill_d = 1'b1; res_d = XLEN'(DEF_RES);
`endif
      end
    end
    if (alu_if.flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE; res_q <= '0; ill_q <= 1'b0; sel_q <= 1'b0;
    end else begin
      state_q <= state_d; res_q <= res_d; ill_q <= ill_d; sel_q <= sel_d;
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (md_start),
    .abort_i  (alu_if.flush_i),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  assign alu_if.valid_o   = (state_q == ST_DONE);
  assign alu_if.result_o  = sel_q ? md_res : res_q;
  assign alu_if.illegal_o = ill_q;

endmodule
